// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM encoding and line helpers for cache_refill_controller
package cache_pkg;

  localparam int TAG_W    = 18;
  localparam int IDX_W    = 10;
  localparam int OFS_W    = 2;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;
  localparam int BEATS    = 4;

  // Byte-address field boundaries: [31:TAG_LSB] tag, [TAG_LSB-1:IDX_LSB] index, [3:2] word
  localparam int IDX_LSB  = 4;
  localparam int WORD_LSB = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REFILL = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Select one 32-bit word from a 128-bit line; word 0 sits in the low bits
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFS_W-1:0]  sel);
    case (sel)
      2'd0:    line_word = line[31:0];
      2'd1:    line_word = line[63:32];
      2'd2:    line_word = line[95:64];
      default: line_word = line[127:96];
    endcase
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - data/tag arrays with reset-cleared valid bits, one read and one write port
module cache_line_store
  import cache_pkg::*;
#(
  parameter int LINES = 1024,
  parameter int IW    = 10,
  parameter int TW    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     rd_idx_i,
  output logic              rd_valid_o,
  output logic [TW-1:0]     rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              we_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [TW-1:0]     wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic [LINE_W-1:0] data_q [LINES];
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  // Data and tag are plain storage; only the valid bits need a defined reset value
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[wr_idx_i] <= wr_line_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

  // Valid bits clear on reset and are set by a line fill; nothing ever clears one otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_refill_controller.sv
// rtl/cache_refill_controller.sv - direct-mapped read cache controller with 4-beat refill; CACHE_STATS_EN enables hit/miss counters
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LINES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ready,
  output logic             cpu_valid,
  output logic [31:0]      cpu_data,
  output logic             cpu_hit,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - IW - IDX_LSB;

  state_e             state_q;
  logic               cpu_ready_q;
  logic               cpu_valid_q;
  logic [31:0]        cpu_data_q;
  logic               cpu_hit_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic [1:0]         beat_q;
  logic [TW-1:0]      tag_q;
  logic [IW-1:0]      idx_q;
  logic [OFS_W-1:0]   word_q;
  logic [31:0]        buf_q [BEATS];

  logic               rd_valid;
  logic [TW-1:0]      rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic [LINE_W-1:0]  fill_line;
  logic               hit;
  logic               fill_we;

  // Byte-select bits play no part in a word-wide read
  logic               unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[WORD_LSB-1:0];

  assign fill_line = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
  assign hit       = rd_valid && (rd_tag == tag_q);
  assign fill_we   = (state_q == FILL);

  cache_line_store #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst),
    .rd_idx_i   (idx_q),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .we_i       (fill_we),
    .wr_idx_i   (idx_q),
    .wr_tag_i   (tag_q),
    .wr_line_i  (fill_line)
  );

  // Request sequencer: accept, look up, refill word-serially, fill the line, respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cpu_ready_q <= 1'b1;
      cpu_valid_q <= 1'b0;
      cpu_data_q  <= '0;
      cpu_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      beat_q      <= '0;
      tag_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      for (int i = 0; i < BEATS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      cpu_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            tag_q       <= cpu_addr[31 -: TW];
            idx_q       <= cpu_addr[IDX_LSB +: IW];
            word_q      <= cpu_addr[WORD_LSB +: OFS_W];
            cpu_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data_q <= line_word(rd_line, word_q);
            cpu_hit_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {tag_q, idx_q, 4'b0000};
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack && mem_req_q) begin
            buf_q[beat_q] <= mem_data;
            if (beat_q == 2'd3) begin
              mem_req_q <= 1'b0;
              state_q   <= FILL;
            end else begin
              beat_q     <= beat_q + 2'd1;
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        FILL: begin
          cpu_data_q <= line_word(fill_line, word_q);
          cpu_hit_q  <= 1'b0;
          state_q    <= RESP;
        end
        RESP: begin
          cpu_valid_q <= 1'b1;
          cpu_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          mem_req_q   <= 1'b0;
          cpu_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Saturating lookup outcome counters, stepped once per accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  assign cpu_ready = cpu_ready_q;
  assign cpu_valid = cpu_valid_q;
  assign cpu_data  = cpu_data_q;
  assign cpu_hit   = cpu_hit_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// tb/tb_cache_refill_controller.sv - directed table-driven bench for cache_refill_controller
module tb_cache_refill_controller;

  localparam int CNT_W = 16;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req;
  logic [31:0]      cpu_addr;
  logic             cpu_ready;
  logic             cpu_valid;
  logic [31:0]      cpu_data;
  logic             cpu_hit;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_data;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int total = 0;
  int bad   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  typedef struct {
    logic [31:0]       addr;
    logic [31:0]       base;
    logic [3:0][31:0]  words;
    int                stall;
    bit                busy_req;
    bit                exp_hit;
    logic [31:0]       exp_data;
    int                exp_lat;
  } vec_t;

  vec_t vecs [10];

  cache_refill_controller #(.CNT_W(CNT_W), .LINES(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_valid  (cpu_valid),
    .cpu_data   (cpu_data),
    .cpu_hit    (cpu_hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] base,
                              input logic [127:0] words, input int stall, input bit busy,
                              input bit hit, input logic [31:0] data, input int lat);
    vec_t v;
    v.addr = addr; v.base = base; v.words = words; v.stall = stall; v.busy_req = busy;
    v.exp_hit = hit; v.exp_data = data; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string name);
    check({name, "_hit_count"},  32'(hit_count),  STATS ? 32'(exp_hits) : 32'd0);
    check({name, "_miss_count"}, 32'(miss_count), STATS ? 32'(exp_miss) : 32'd0);
  endtask

  task automatic do_read(input vec_t v, input string name);
    int cyc;
    int beat;
    int stall_cnt;
    int guard;
    bit got;
    bit saw_mem;
    guard = 0;
    @(negedge clk);
    while (!cpu_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_ready"}, 32'(cpu_ready), 32'd1);
    cpu_req  = 1'b1;
    cpu_addr = v.addr;
    @(posedge clk);
    #1;
    cpu_addr = v.busy_req ? 32'hFFFF_FFF0 : 32'h1234_5678;
    if (!v.busy_req) cpu_req = 1'b0;
    cyc = -1; beat = 0; stall_cnt = 0; got = 1'b0; saw_mem = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_ack  = 1'b0;
      mem_data = 32'hBAD0_0000 + 32'(cyc);
      if (cpu_valid) begin
        got     = 1'b1;
        cpu_req = 1'b0;
      end else if (mem_req) begin
        saw_mem = 1'b1;
        check($sformatf("%s_mem_addr_b%0d", name, beat), mem_addr, v.base + 32'(4 * beat));
        if (stall_cnt < v.stall) begin
          stall_cnt++;
        end else if (beat < 4) begin
          mem_ack   = 1'b1;
          mem_data  = v.words[beat];
          beat++;
          stall_cnt = 0;
        end
      end
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    if (v.exp_hit) exp_hits++; else exp_miss++;
    check({name, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    check({name, "_data"}, cpu_data, v.exp_data);
    check({name, "_hit"}, 32'(cpu_hit), 32'(v.exp_hit));
    check({name, "_mem_used"}, 32'(saw_mem), 32'(!v.exp_hit));
    check({name, "_beats"}, 32'(beat), v.exp_hit ? 32'd0 : 32'd4);
    @(negedge clk);
    check({name, "_valid_pulse"}, {30'd0, cpu_valid, cpu_ready}, 32'd1);
    check_counters(name);
  endtask

  initial begin
    rst      = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = 32'h0;
    mem_ack  = 1'b0;
    mem_data = 32'h0;

    vecs[0] = mk(32'h0000_0040, 32'h0000_0040, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0, 1'b0, 32'h11, 7);
    vecs[1] = mk(32'h0000_0048, 32'h0, 128'h0, 0, 1'b0, 1'b1, 32'h33, 2);
    vecs[2] = mk(32'h0000_004C, 32'h0, 128'h0, 0, 1'b0, 1'b1, 32'h44, 2);
    vecs[3] = mk(32'h0000_4040, 32'h0000_4040, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b0, 1'b0, 32'hA0, 7);
    vecs[4] = mk(32'h0000_0044, 32'h0000_0040, {32'h88, 32'h77, 32'h66, 32'h55}, 0, 1'b0, 1'b0, 32'h66, 7);
    vecs[5] = mk(32'h0003_FFF8, 32'h0003_FFF0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 3, 1'b0, 1'b0, 32'hC2, 19);
    vecs[6] = mk(32'h0003_FFFC, 32'h0, 128'h0, 0, 1'b0, 1'b1, 32'hC3, 2);
    vecs[7] = mk(32'hFFFF_C000, 32'hFFFF_C000, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1, 1'b0, 1'b0, 32'hD0, 11);
    vecs[8] = mk(32'h0000_0048, 32'h0, 128'h0, 0, 1'b0, 1'b1, 32'h77, 2);
    vecs[9] = mk(32'h0000_4043, 32'h0000_4040, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 0, 1'b1, 1'b0, 32'hE0, 7);

    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, cpu_ready, cpu_valid, cpu_hit, mem_req}, 32'h8);
    check("reset_cpu_data", cpu_data, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check_counters("reset");
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i], $sformatf("v%0d", i));
    end

    // Stray mem_ack while idle must not start or disturb anything
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack  = 1'b1;
      mem_data = 32'hFFFF_FFFF;
      @(negedge clk);
      check($sformatf("stray_ack_%0d", i), {29'd0, mem_req, cpu_valid, cpu_ready}, 32'd1);
    end
    mem_ack = 1'b0;
    do_read(mk(32'h0000_4048, 32'h0, 128'h0, 0, 1'b0, 1'b1, 32'hE2, 2), "after_stray");

    // Reset in the middle of a refill, after two beats have been accepted
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0040;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check($sformatf("abort_mem_req_b%0d", b), 32'(mem_req), 32'd1);
      mem_ack  = 1'b1;
      mem_data = 32'h9000_0000 + 32'(b);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("abort_mem_addr_b2", mem_addr, 32'h0000_0048);
    rst = 1'b0;
    #1;
    check("abort_reset_state", {29'd0, mem_req, cpu_valid, cpu_ready}, 32'd1);
    check("abort_reset_mem_addr", mem_addr, 32'h0);
    exp_hits = 0;
    exp_miss = 0;
    check_counters("abort_reset");
    @(negedge clk);
    rst = 1'b1;
    do_read(mk(32'h0000_4040, 32'h0000_4040, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 1'b0, 1'b0, 32'hF0, 7), "post_reset_miss");
    do_read(mk(32'h0000_4044, 32'h0, 128'h0, 0, 1'b0, 1'b1, 32'hF1, 2), "post_reset_hit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
